// File: rtl/lab2_proc_mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// lab2_proc_mem_arb_pkg
//
// Shared definitions for the processor memory-port arbiter:
//   - port identifiers (imem = 0, dmem = 1) and the owner-id type
//   - 4-byte memory request/response message layouts
//       mem_req_4B_t  (77 bits): type, opaque, addr, len, data
//       mem_resp_4B_t (47 bits): type, opaque, test, len, data
//   - a small helper returning the other port id
// ----------------------------------------------------------------------------

package lab2_proc_mem_arb_pkg;

    typedef logic [0:0] owner_t;

    localparam owner_t c_port_imem = 1'b0;
    localparam owner_t c_port_dmem = 1'b1;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    function automatic owner_t other_port(input owner_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/lab2_proc_mem_arb_owner_queue.sv
// ----------------------------------------------------------------------------
// lab2_proc_mem_arb_owner_queue
//
// Circular buffer of 1-bit owner ids, one entry per in-flight memory request.
// The head entry names the port that must receive the next memory response.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-low reset
//   push       enqueue push_data (ignored when full)
//   push_data  owner id of the request being issued
//   pop        dequeue the head entry (ignored when empty)
//   head_data  owner id at the head
//   full       count == p_max_outstanding
//   empty      count == 0
// ----------------------------------------------------------------------------

module lab2_proc_mem_arb_owner_queue
    import lab2_proc_mem_arb_pkg::*;
#(
    parameter int unsigned p_max_outstanding = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  owner_t push_data,
    input  logic   pop,
    output owner_t head_data,
    output logic   full,
    output logic   empty
);

    localparam int unsigned c_ptr_w = $clog2(p_max_outstanding);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;

    logic [p_max_outstanding-1:0] entries_q;
    logic [c_ptr_w-1:0]           head_q;
    logic [c_ptr_w-1:0]           tail_q;
    logic [c_cnt_w-1:0]           count_q;

    logic push_ok;
    logic pop_ok;

    assign full      = (count_q == c_cnt_w'(p_max_outstanding));
    assign empty     = (count_q == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = entries_q[head_q];

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            if (push_ok) begin
                entries_q[tail_q] <= push_data;
                tail_q            <= tail_q + c_ptr_w'(1);
            end
            if (pop_ok) begin
                head_q <= head_q + c_ptr_w'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + c_cnt_w'(1);
                2'b01:   count_q <= count_q - c_cnt_w'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/lab2_proc_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// lab2_proc_mem_port_arbiter
//
// Shares one memory port between instruction fetch (port 0, imem) and data
// memory (port 1, dmem). Requests are arbitrated combinationally with a grant
// lock that keeps a stalled request stable; responses are steered back to the
// issuing port in order via an owner queue.
//
// Configuration macro:
//   LAB2_PROC_MEM_ARB_RR_EN  defined   -> round-robin on ties (rr_last)
//                            undefined -> fixed priority, dmem wins ties
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   imemreq_val/rdy/msg             port-0 request  (mem_req_4B_t)
//   imemresp_val/rdy/msg            port-0 response (mem_resp_4B_t)
//   dmemreq_val/rdy/msg             port-1 request
//   dmemresp_val/rdy/msg            port-1 response
//   memreq_val/rdy/msg              shared memory request
//   memresp_val/rdy/msg             shared memory response
// ----------------------------------------------------------------------------

module lab2_proc_mem_port_arbiter
    import lab2_proc_mem_arb_pkg::*;
#(
    parameter int unsigned p_max_outstanding = 4
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         imemreq_val,
    output logic         imemreq_rdy,
    input  mem_req_4B_t  imemreq_msg,

    output logic         imemresp_val,
    input  logic         imemresp_rdy,
    output mem_resp_4B_t imemresp_msg,

    input  logic         dmemreq_val,
    output logic         dmemreq_rdy,
    input  mem_req_4B_t  dmemreq_msg,

    output logic         dmemresp_val,
    input  logic         dmemresp_rdy,
    output mem_resp_4B_t dmemresp_msg,

    output logic         memreq_val,
    input  logic         memreq_rdy,
    output mem_req_4B_t  memreq_msg,

    input  logic         memresp_val,
    output logic         memresp_rdy,
    input  mem_resp_4B_t memresp_msg
);

    owner_t      grant;
    owner_t      tie_winner;
    logic        grant_val;
    mem_req_4B_t grant_msg;

    logic        lock_vld_q;
    owner_t      lock_port_q;

    logic        q_full;
    logic        q_empty;
    owner_t      head_owner;
    logic        req_fire;
    logic        resp_fire;
    logic        resp_ok;

    // ------------------------------------------------------------------
    // Tie-break policy
    // ------------------------------------------------------------------
`ifdef LAB2_PROC_MEM_ARB_RR_EN
    owner_t rr_last_q;

    assign tie_winner = other_port(rr_last_q);

    // Reset to dmem so that imem wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last_q <= c_port_dmem;
        end else if (req_fire) begin
            rr_last_q <= grant;
        end
    end
`else
    // dmem carries the older instruction, so it wins ties.
    assign tie_winner = c_port_dmem;
`endif

    // ------------------------------------------------------------------
    // Grant selection and request steering
    // ------------------------------------------------------------------
    always_comb begin
        grant = tie_winner;
        if (lock_vld_q) begin
            grant = lock_port_q;
        end else if (imemreq_val && !dmemreq_val) begin
            grant = c_port_imem;
        end else if (dmemreq_val && !imemreq_val) begin
            grant = c_port_dmem;
        end
    end

    assign grant_val = (grant == c_port_dmem) ? dmemreq_val : imemreq_val;
    assign grant_msg = (grant == c_port_dmem) ? dmemreq_msg : imemreq_msg;

    // Full queue blocks issue outright: a same-cycle pop does not make room.
    always_comb begin
        memreq_val  = reset && !q_full && grant_val;
        memreq_msg  = reset ? grant_msg : '0;
        imemreq_rdy = reset && !q_full && (grant == c_port_imem) && memreq_rdy;
        dmemreq_rdy = reset && !q_full && (grant == c_port_dmem) && memreq_rdy;
    end

    assign req_fire = memreq_val && memreq_rdy;

    // Hold the grant while a presented request is stalled so memreq_msg stays
    // stable; while full, nothing is presented and the lock is simply kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_vld_q  <= 1'b0;
            lock_port_q <= c_port_imem;
        end else if (!q_full) begin
            lock_vld_q  <= memreq_val && !memreq_rdy;
            lock_port_q <= grant;
        end
    end

    // ------------------------------------------------------------------
    // Owner queue
    // ------------------------------------------------------------------
    lab2_proc_mem_arb_owner_queue #(
        .p_max_outstanding (p_max_outstanding)
    ) owner_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (req_fire),
        .push_data (grant),
        .pop       (resp_fire),
        .head_data (head_owner),
        .full      (q_full),
        .empty     (q_empty)
    );

    // ------------------------------------------------------------------
    // Response steering
    // ------------------------------------------------------------------
    // With nothing outstanding a response has no owner: it is held, not routed.
    assign resp_ok = reset && !q_empty;

    always_comb begin
        imemresp_val = resp_ok && (head_owner == c_port_imem) && memresp_val;
        dmemresp_val = resp_ok && (head_owner == c_port_dmem) && memresp_val;
        imemresp_msg = (resp_ok && (head_owner == c_port_imem)) ? memresp_msg : '0;
        dmemresp_msg = (resp_ok && (head_owner == c_port_dmem)) ? memresp_msg : '0;
        memresp_rdy  = resp_ok &&
                       ((head_owner == c_port_dmem) ? dmemresp_rdy : imemresp_rdy);
    end

    assign resp_fire = memresp_val && memresp_rdy;

endmodule

// File: tb/tb_lab2_proc_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_lab2_proc_mem_port_arbiter
//
// Directed stimulus with a scoreboard: expected memory requests and expected
// per-port responses are queued as stimulus is issued; a negedge monitor pops
// and compares on every fire. Tie expectations follow LAB2_PROC_MEM_ARB_RR_EN.
// ----------------------------------------------------------------------------

module tb_lab2_proc_mem_port_arbiter;
    import lab2_proc_mem_arb_pkg::*;

    localparam logic [2:0] c_rd = 3'd0;
    localparam logic [2:0] c_wr = 3'd1;

    logic         clk;
    logic         reset;
    logic         imemreq_val,  imemreq_rdy;
    mem_req_4B_t  imemreq_msg;
    logic         imemresp_val, imemresp_rdy;
    mem_resp_4B_t imemresp_msg;
    logic         dmemreq_val,  dmemreq_rdy;
    mem_req_4B_t  dmemreq_msg;
    logic         dmemresp_val, dmemresp_rdy;
    mem_resp_4B_t dmemresp_msg;
    logic         memreq_val,   memreq_rdy;
    mem_req_4B_t  memreq_msg;
    logic         memresp_val,  memresp_rdy;
    mem_resp_4B_t memresp_msg;

    mem_req_4B_t  exp_req_q[$];
    mem_resp_4B_t exp_iresp_q[$];
    mem_resp_4B_t exp_dresp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    lab2_proc_mem_port_arbiter #(
        .p_max_outstanding (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imemreq_val  (imemreq_val),
        .imemreq_rdy  (imemreq_rdy),
        .imemreq_msg  (imemreq_msg),
        .imemresp_val (imemresp_val),
        .imemresp_rdy (imemresp_rdy),
        .imemresp_msg (imemresp_msg),
        .dmemreq_val  (dmemreq_val),
        .dmemreq_rdy  (dmemreq_rdy),
        .dmemreq_msg  (dmemreq_msg),
        .dmemresp_val (dmemresp_val),
        .dmemresp_rdy (dmemresp_rdy),
        .dmemresp_msg (dmemresp_msg),
        .memreq_val   (memreq_val),
        .memreq_rdy   (memreq_rdy),
        .memreq_msg   (memreq_msg),
        .memresp_val  (memresp_val),
        .memresp_rdy  (memresp_rdy),
        .memresp_msg  (memresp_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
        $fatal(1);
    end

    function automatic mem_req_4B_t mk_req(input logic [2:0] t, input logic [7:0] op,
                                           input logic [31:0] addr, input logic [31:0] data);
        mem_req_4B_t m;
        m.typ = t; m.opaque = op; m.addr = addr; m.len = 2'd0; m.data = data;
        return m;
    endfunction

    function automatic mem_resp_4B_t mk_resp(input logic [7:0] op, input logic [31:0] data);
        mem_resp_4B_t m;
        m.typ = c_rd; m.opaque = op; m.test = 2'd0; m.len = 2'd0; m.data = data;
        return m;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic note_unexpected(input string name, input logic [127:0] got);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got unexpected fire %0h required no fire", name, got);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            if (memreq_val && memreq_rdy) begin
                if (exp_req_q.size() == 0) note_unexpected("memreq", memreq_msg);
                else check("memreq_msg", memreq_msg, exp_req_q.pop_front());
            end
            if (imemresp_val && imemresp_rdy) begin
                if (exp_iresp_q.size() == 0) note_unexpected("imemresp", imemresp_msg);
                else check("imemresp_msg", imemresp_msg, exp_iresp_q.pop_front());
            end
            if (dmemresp_val && dmemresp_rdy) begin
                if (exp_dresp_q.size() == 0) note_unexpected("dmemresp", dmemresp_msg);
                else check("dmemresp_msg", dmemresp_msg, exp_dresp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imemreq_val  = 1'b0; imemreq_msg = '0;
        dmemreq_val  = 1'b0; dmemreq_msg = '0;
        imemresp_rdy = 1'b1; dmemresp_rdy = 1'b1;
        memreq_rdy   = 1'b1;
        memresp_val  = 1'b0; memresp_msg = '0;
    endtask

    task automatic do_reset();
        check("leftover exp_req", exp_req_q.size(), 0);
        check("leftover exp_iresp", exp_iresp_q.size(), 0);
        check("leftover exp_dresp", exp_dresp_q.size(), 0);
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step();
    endtask

    mem_req_4B_t  ra, rb, ri, rd;
    mem_resp_4B_t pr;
    logic         g, g_prev;

    initial begin
        idle_inputs();
        reset = 1'b0;

        // Reset state with active inputs
        imemreq_val = 1'b1; dmemreq_val = 1'b1; memresp_val = 1'b1;
        imemreq_msg = mk_req(c_rd, 8'h11, 32'h44, 32'h0);
        memresp_msg = mk_resp(8'h22, 32'h99);
        repeat (2) @(posedge clk);
        #1;
        check("rst memreq_val", memreq_val, 0);
        check("rst memreq_msg", memreq_msg, 0);
        check("rst imemreq_rdy", imemreq_rdy, 0);
        check("rst dmemreq_rdy", dmemreq_rdy, 0);
        check("rst memresp_rdy", memresp_rdy, 0);
        check("rst imemresp_val", imemresp_val, 0);
        check("rst dmemresp_val", dmemresp_val, 0);
        check("rst dmemresp_msg", dmemresp_msg, 0);
        idle_inputs();
        reset = 1'b1;
        step();

        // T1: single port-0 read at 0x200
        ra = mk_req(c_rd, 8'h01, 32'h200, 32'h0);
        imemreq_val = 1'b1; imemreq_msg = ra;
        exp_req_q.push_back(ra);
        #1;
        check("t1 memreq_msg comb", memreq_msg, ra);
        check("t1 imemreq_rdy", imemreq_rdy, 1);
        check("t1 dmemreq_rdy", dmemreq_rdy, 0);
        step();
        imemreq_val = 1'b0;
        pr = mk_resp(8'h01, 32'h13);
        memresp_val = 1'b1; memresp_msg = pr;
        exp_iresp_q.push_back(pr);
        #1;
        check("t1 dmemresp_val", dmemresp_val, 0);
        check("t1 memresp_rdy", memresp_rdy, 1);
        step();
        // Queue drained: a stray response is held
        #1;
        check("t1 memresp_rdy empty", memresp_rdy, 0);
        check("t1 imemresp_val empty", imemresp_val, 0);
        memresp_val = 1'b0;

        // T2: both ports valid for 8 cycles, memory always ready
        do_reset();
        g_prev = 1'b0;
        for (int k = 0; k <= 8; k++) begin
`ifdef LAB2_PROC_MEM_ARB_RR_EN
            g = (k % 2 == 1);
`else
            g = 1'b1;
`endif
            if (k < 8) begin
                ri = mk_req(c_rd, 8'(k), 32'h1000 + 32'(k), 32'h0);
                rd = mk_req(c_wr, 8'(8'h80 + k), 32'h2000 + 32'(k), 32'(k));
                imemreq_val = 1'b1; imemreq_msg = ri;
                dmemreq_val = 1'b1; dmemreq_msg = rd;
                exp_req_q.push_back(g ? rd : ri);
            end else begin
                imemreq_val = 1'b0; dmemreq_val = 1'b0;
            end
            if (k > 0) begin
                pr = mk_resp(8'(k - 1), 32'h100 + 32'(k - 1));
                memresp_val = 1'b1; memresp_msg = pr;
                if (g_prev) exp_dresp_q.push_back(pr);
                else        exp_iresp_q.push_back(pr);
            end
            if (k < 8) begin
                #1;
                check("t2 dmemreq_rdy grant", dmemreq_rdy, g);
                check("t2 imemreq_rdy grant", imemreq_rdy, !g);
            end
            g_prev = g;
            step();
        end
        memresp_val = 1'b0;

        // T3: grant lock while memory stalls
        do_reset();
        ra = mk_req(c_rd, 8'h30, 32'h300, 32'h0);
        rb = mk_req(c_wr, 8'h31, 32'h400, 32'h55);
        imemreq_val = 1'b1; imemreq_msg = ra; memreq_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                dmemreq_val = 1'b1; dmemreq_msg = rb;
            end
            #1;
            check("t3 memreq_msg locked", memreq_msg, ra);
            check("t3 memreq_val", memreq_val, 1);
            if (c == 2) check("t3 dmemreq_rdy locked out", dmemreq_rdy, 0);
            step();
        end
        memreq_rdy = 1'b1;
        exp_req_q.push_back(ra);
        #1;
        check("t3 imemreq_rdy fire", imemreq_rdy, 1);
        step();
        imemreq_val = 1'b0;
        exp_req_q.push_back(rb);
        #1;
        check("t3 dmemreq_rdy after", dmemreq_rdy, 1);
        step();
        dmemreq_val = 1'b0;

        // T4: queue full at 4 outstanding, no bypass on same-cycle pop
        do_reset();
        dmemreq_val = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rd = mk_req(c_rd, 8'(8'h40 + k), 32'h500 + 32'(4 * k), 32'h0);
            dmemreq_msg = rd;
            exp_req_q.push_back(rd);
            step();
        end
        rd = mk_req(c_rd, 8'h44, 32'h510, 32'h0);
        dmemreq_msg = rd;
        #1;
        check("t4 dmemreq_rdy full", dmemreq_rdy, 0);
        check("t4 memreq_val full", memreq_val, 0);
        step();
        pr = mk_resp(8'h40, 32'h77);
        memresp_val = 1'b1; memresp_msg = pr;
        exp_dresp_q.push_back(pr);
        #1;
        check("t4 dmemreq_rdy no bypass", dmemreq_rdy, 0);
        check("t4 memreq_val no bypass", memreq_val, 0);
        check("t4 memresp_rdy", memresp_rdy, 1);
        step();
        memresp_val = 1'b0;
        exp_req_q.push_back(rd);
        #1;
        check("t4 dmemreq_rdy room", dmemreq_rdy, 1);
        step();
        dmemreq_val = 1'b0;

        // T5: interleaved d,i,d with in-order responses A,B,C
        do_reset();
        rd = mk_req(c_rd, 8'h50, 32'h600, 32'h0);
        dmemreq_val = 1'b1; dmemreq_msg = rd; exp_req_q.push_back(rd);
        step();
        dmemreq_val = 1'b0;
        ri = mk_req(c_rd, 8'h51, 32'h700, 32'h0);
        imemreq_val = 1'b1; imemreq_msg = ri; exp_req_q.push_back(ri);
        step();
        imemreq_val = 1'b0;
        rd = mk_req(c_wr, 8'h52, 32'h604, 32'h9);
        dmemreq_val = 1'b1; dmemreq_msg = rd; exp_req_q.push_back(rd);
        step();
        dmemreq_val = 1'b0;
        pr = mk_resp(8'h50, 32'hA);
        memresp_val = 1'b1; memresp_msg = pr; exp_dresp_q.push_back(pr);
        #1;
        check("t5 imemresp_val head d", imemresp_val, 0);
        check("t5 dmemresp_val head d", dmemresp_val, 1);
        step();
        pr = mk_resp(8'h51, 32'hB);
        memresp_msg = pr; exp_iresp_q.push_back(pr);
        #1;
        check("t5 dmemresp_val head i", dmemresp_val, 0);
        step();
        pr = mk_resp(8'h52, 32'hC);
        memresp_msg = pr; dmemresp_rdy = 1'b0;
        #1;
        check("t5 memresp_rdy stalled", memresp_rdy, 0);
        check("t5 dmemresp_val held", dmemresp_val, 1);
        step();
        dmemresp_rdy = 1'b1; exp_dresp_q.push_back(pr);
        #1;
        check("t5 memresp_rdy resumed", memresp_rdy, 1);
        step();
        memresp_val = 1'b0;
        #1;
        check("t5 memresp_rdy drained", memresp_rdy, 0);

        // T6: reset with 2 requests outstanding
        do_reset();
        rd = mk_req(c_rd, 8'h60, 32'h800, 32'h0);
        dmemreq_val = 1'b1; dmemreq_msg = rd; exp_req_q.push_back(rd);
        step();
        dmemreq_val = 1'b0;
        ri = mk_req(c_rd, 8'h61, 32'h900, 32'h0);
        imemreq_val = 1'b1; imemreq_msg = ri; exp_req_q.push_back(ri);
        step();
        dmemreq_val = 1'b1;
        memresp_val = 1'b1; memresp_msg = mk_resp(8'h60, 32'h66);
        reset = 1'b0;
        #1;
        check("t6 memreq_val", memreq_val, 0);
        check("t6 memreq_msg", memreq_msg, 0);
        check("t6 imemreq_rdy", imemreq_rdy, 0);
        check("t6 dmemreq_rdy", dmemreq_rdy, 0);
        check("t6 memresp_rdy", memresp_rdy, 0);
        check("t6 dmemresp_val", dmemresp_val, 0);
        check("t6 dmemresp_msg", dmemresp_msg, 0);
        step();
        imemreq_val = 1'b0; dmemreq_val = 1'b0;
        reset = 1'b1;
        #1;
        check("t6 late memresp_rdy", memresp_rdy, 0);
        check("t6 late dmemresp_val", dmemresp_val, 0);
        step();
        check("t6 late memresp_rdy held", memresp_rdy, 0);
        memresp_val = 1'b0;
        step();

        check("final exp_req empty", exp_req_q.size(), 0);
        check("final exp_iresp empty", exp_iresp_q.size(), 0);
        check("final exp_dresp empty", exp_dresp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
